// File: rtl/ppu_pixmux.sv
// PPU final pixel stage: bg/sprite merge, sprite-0 hit, 32x6 palette RAM with $2007 access.
// Optional: PPU_PIXMUX_EMPH_EN widens pixel to 9 bits with the emphasis bits in the top.
module ppu_pixmux (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [8:0] ppux,
    input  logic [8:0] ppuy,
    input  logic [3:0] bgpix,
    input  logic [3:0] sprpix,
    input  logic       sprpri,
    input  logic       sprzero,
    input  logic [7:0] ppumask,
    input  logic       upalacc,
    input  logic [4:0] upaladdr,
    input  logic [7:0] regwdata,
    input  logic       wr2007,
    input  logic       rd2007,
    output logic [5:0] paldata,
`ifdef PPU_PIXMUX_EMPH_EN
    output logic [8:0] pixel,
`else
    output logic [5:0] pixel,
`endif
    output logic       pixvalid,
    output logic       sprite0hit
);

    localparam int unsigned PAL_DEPTH = 32;
    localparam int unsigned COL_W     = 6;
    localparam int unsigned IDX_W     = 5;

    // Sprite palette backdrop entries alias the background ones.
    function automatic logic [IDX_W-1:0] pal_mirror(input logic [IDX_W-1:0] a);
        return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

    logic [COL_W-1:0] pal [PAL_DEPTH];

    logic             in_win;
    logic             left8;
    logic             last_col;
    logic             bg_op;
    logic             spr_op;
    logic             force_bd;
    logic [IDX_W-1:0] idx_c;
    logic [COL_W-1:0] col_c;
    logic             s0_set;
    logic             s0_clr;

    logic [IDX_W-1:0] idx1;
    logic             v1;

    assign in_win   = (ppuy <= 9'd239) && (ppux >= 9'd2) && (ppux <= 9'd257);
    assign left8    = (ppux < 9'd10);
    assign last_col = (ppux == 9'd257);
    assign force_bd = !ppumask[3] && !ppumask[4] && upalacc;

    // Stage-1 opacity and priority selection.
    always_comb begin
        bg_op  = ppumask[3] && (bgpix[1:0] != 2'b00) && !(left8 && !ppumask[1]);
        spr_op = ppumask[4] && (sprpix[1:0] != 2'b00) && !(left8 && !ppumask[2]);
        idx_c  = 5'h00;
        if (force_bd)
            idx_c = upaladdr;
        else if (bg_op && spr_op)
            idx_c = sprpri ? {1'b0, bgpix} : {1'b1, sprpix};
        else if (bg_op)
            idx_c = {1'b0, bgpix};
        else if (spr_op)
            idx_c = {1'b1, sprpix};
    end

    assign col_c  = pal[pal_mirror(idx1)] & (ppumask[0] ? 6'h30 : 6'h3f);
    assign s0_set = in_win && bg_op && spr_op && sprzero && !last_col;
    assign s0_clr = (ppuy == 9'd261) && (ppux == 9'd1);

    // Palette storage has no reset; a same-tick render lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (tick && wr2007 && upalacc)
            pal[pal_mirror(upaladdr)] <= regwdata[5:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx1       <= '0;
            v1         <= 1'b0;
            pixel      <= '0;
            pixvalid   <= 1'b0;
            sprite0hit <= 1'b0;
            paldata    <= '0;
        end else if (tick) begin
            v1       <= in_win;
            if (in_win)
                idx1 <= idx_c;
            pixvalid <= v1;
            if (v1)
`ifdef PPU_PIXMUX_EMPH_EN
                pixel <= {ppumask[7:5], col_c};
`else
                pixel <= col_c;
`endif
            if (s0_clr)
                sprite0hit <= 1'b0;
            else if (s0_set)
                sprite0hit <= 1'b1;
            if (rd2007 && upalacc)
                paldata <= pal[pal_mirror(upaladdr)];
        end
    end

`ifdef PPU_PIXMUX_EMPH_EN
    logic unused_bits;
    assign unused_bits = ^regwdata[7:6];
`else
    logic unused_bits;
    assign unused_bits = ^{regwdata[7:6], ppumask[7:5]};
`endif

endmodule
